// File: rtl/vga_pkg.sv
// Shared geometry, widths and FSM state encoding for the VGA pixel scheduler.
package vga_pkg;

   localparam int unsigned PW        = 40;
   localparam int unsigned PH        = 30;
   localparam int unsigned PIX_COUNT = PW * PH;
   localparam int unsigned IDX_W     = 11;
   localparam int unsigned RGB_W     = 12;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_HI   = 2'd1;
   localparam state_t S_LO   = 2'd2;
   localparam state_t S_CLR  = 2'd3;

endpackage

// File: rtl/vga_pulse_gen.sv
// HOLD/GAP timer for one add_input pulse.
// o_hi is the add_input level for the cycle after the coming edge, so the caller can
// register it directly; o_done marks the final GAP cycle of the running pulse.
module vga_pulse_gen #(
   parameter int unsigned HOLD = 2,
   parameter int unsigned GAP  = 2
) (
   input  logic clk_50,
   input  logic reset,
   input  logic i_go,
   input  logic i_abort,
   output logic o_hi,
   output logic o_done
);

   localparam int unsigned      CNT_W   = $clog2(HOLD + GAP + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_HI = CNT_W'(HOLD);
   localparam logic [CNT_W-1:0] LAST_LO = CNT_W'(HOLD + GAP);

   // 0 = no pulse; 1..HOLD = high cycles; HOLD+1..HOLD+GAP = low cycles
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;

   // Next count: abort wins, a new pulse may start on the last low cycle
   always_comb begin
      w_cnt_d = '0;
      if (i_abort) begin
         w_cnt_d = '0;
      end else if (i_go) begin
         w_cnt_d = CNT_ONE;
      end else if ((r_cnt != '0) && (r_cnt != LAST_LO)) begin
         w_cnt_d = r_cnt + CNT_ONE;
      end
   end

   // Pulse position register
   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

   assign o_done = (r_cnt == LAST_LO);
   assign o_hi   = (w_cnt_d != '0) && (w_cnt_d <= LAST_HI);

endmodule

// File: rtl/vga_pixel_scheduler.sv
// Write sequencer for the 40x30 image buffer: arbitrates clear, full-screen fill and
// CPU pixels, shapes accepted pixels into clean add_input pulses and mirrors the
// buffer's write pointer. Map geometry comes from vga_pkg.
module vga_pixel_scheduler
   import vga_pkg::*;
#(
   parameter int unsigned HOLD = 2,
   parameter int unsigned GAP  = 2
) (
   input  logic             clk_50,
   input  logic             reset,
   input  logic             clear_req,
   input  logic             cpu_valid,
   input  logic [RGB_W-1:0] cpu_rgb,
   output logic             cpu_ready,
   input  logic             fill_start,
   input  logic [RGB_W-1:0] fill_rgb,
   output logic             fill_busy,
   output logic             out_add_input,
   output logic [RGB_W-1:0] out_rgb,
   output logic             out_buf_reset,
   output logic [IDX_W-1:0] wr_index,
   output logic             frame_done
);

   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PIX_COUNT - 1);
   localparam logic [IDX_W-1:0] FILL_FULL = IDX_W'(PIX_COUNT);

   state_t           r_state;
   state_t           w_state_d;
   logic             r_cpu_ready;
   logic             r_fill_busy;
   logic             r_add;
   logic             r_buf_reset;
   logic             r_frame_done;
   logic [RGB_W-1:0] r_rgb;
   logic [IDX_W-1:0] r_wr_index;
   logic [IDX_W-1:0] r_fill_cnt;   // pulses of the fill still owed, including the running one

   logic w_idle;
   logic w_cpu_acc;
   logic w_fill_acc;
   logic w_fill_next;
   logic w_go;
   logic w_hi;
   logic w_done;

   // cpu_ready is a registered "scheduler is idle" flag; a pixel offered while clear_req
   // or fill_start is also high loses the arbitration and stays with the CPU.
   assign w_idle      = (r_state == S_IDLE);
   assign w_fill_acc  = w_idle & fill_start & ~clear_req;
   assign w_cpu_acc   = r_cpu_ready & cpu_valid & ~fill_start & ~clear_req;
   assign w_fill_next = r_fill_busy & w_done & (r_fill_cnt != IDX_ONE) & ~clear_req;
   assign w_go        = w_cpu_acc | w_fill_acc | w_fill_next;

   vga_pulse_gen #(
      .HOLD (HOLD),
      .GAP  (GAP)
   ) u_pulse_gen (
      .clk_50  (clk_50),
      .reset   (reset),
      .i_go    (w_go),
      .i_abort (clear_req),
      .o_hi    (w_hi),
      .o_done  (w_done)
   );

   // Next FSM state: clear overrides everything, fill pulses chain LO->HI directly
   always_comb begin
      w_state_d = r_state;
      if (clear_req) begin
         w_state_d = S_CLR;
      end else if (w_go) begin
         w_state_d = S_HI;
      end else begin
         case (r_state)
            S_CLR:       w_state_d = S_IDLE;
            S_HI, S_LO:  w_state_d = w_done ? S_IDLE : (w_hi ? S_HI : S_LO);
            default:     w_state_d = S_IDLE;
         endcase
      end
   end

   // State, registered outputs, fill counter and write-pointer mirror
   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cpu_ready  <= 1'b0;
         r_fill_busy  <= 1'b0;
         r_add        <= 1'b0;
         r_buf_reset  <= 1'b0;
         r_frame_done <= 1'b0;
         r_rgb        <= '0;
         r_wr_index   <= '0;
         r_fill_cnt   <= '0;
      end else begin
         r_state      <= w_state_d;
         r_cpu_ready  <= (w_state_d == S_IDLE);
         r_add        <= w_hi;
         r_buf_reset  <= clear_req;
         r_frame_done <= 1'b0;
         if (clear_req) begin
            r_wr_index  <= '0;
            r_fill_busy <= 1'b0;
            r_fill_cnt  <= '0;
         end else begin
            // The buffer advances its pointer on each add_input rise
            if (w_go) begin
               r_wr_index   <= (r_wr_index == IDX_LAST) ? '0 : r_wr_index + IDX_ONE;
               r_frame_done <= (r_wr_index == IDX_LAST);
            end
            if (w_cpu_acc) begin
               r_rgb <= cpu_rgb;
            end
            if (w_fill_acc) begin
               r_rgb       <= fill_rgb;
               r_fill_busy <= 1'b1;
               r_fill_cnt  <= FILL_FULL;
            end else if (r_fill_busy && w_done) begin
               r_fill_cnt <= r_fill_cnt - IDX_ONE;
               if (r_fill_cnt == IDX_ONE) begin
                  r_fill_busy <= 1'b0;
               end
            end
         end
      end
   end

   assign cpu_ready     = r_cpu_ready;
   assign fill_busy     = r_fill_busy;
   assign out_add_input = r_add;
   assign out_rgb       = r_rgb;
   assign out_buf_reset = r_buf_reset;
   assign wr_index      = r_wr_index;
   assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_vga_pixel_scheduler.sv
// Self-checking bench for vga_pixel_scheduler: a per-cycle expectation timeline model,
// a vector table for reset/single-write/priority, directed corner sequences and random traffic.
module tb_vga_pixel_scheduler;
   import vga_pkg::*;

   localparam int HOLD = 2;
   localparam int GAP  = 2;

   logic        clk_50     = 1'b0;
   logic        reset      = 1'b1;
   logic        clear_req  = 1'b0;
   logic        cpu_valid  = 1'b0;
   logic [11:0] cpu_rgb    = '0;
   logic        fill_start = 1'b0;
   logic [11:0] fill_rgb   = '0;
   logic        cpu_ready;
   logic        fill_busy;
   logic        out_add_input;
   logic [11:0] out_rgb;
   logic        out_buf_reset;
   logic [10:0] wr_index;
   logic        frame_done;

   vga_pixel_scheduler #(
      .HOLD (HOLD),
      .GAP  (GAP)
   ) dut (
      .clk_50        (clk_50),
      .reset         (reset),
      .clear_req     (clear_req),
      .cpu_valid     (cpu_valid),
      .cpu_rgb       (cpu_rgb),
      .cpu_ready     (cpu_ready),
      .fill_start    (fill_start),
      .fill_rgb      (fill_rgb),
      .fill_busy     (fill_busy),
      .out_add_input (out_add_input),
      .out_rgb       (out_rgb),
      .out_buf_reset (out_buf_reset),
      .wr_index      (wr_index),
      .frame_done    (frame_done)
   );

   always #10 clk_50 = ~clk_50;

   int checks   = 0;
   int failures = 0;
   int rises    = 0;
   int frames   = 0;
   logic prev_add = 1'b0;

   // Model: a timeline of expected add_input slots for upcoming cycles
   typedef struct packed {
      logic add;
      logic rise;
      logic fill;
   } slot_t;

   slot_t       sched[$];
   logic        m_idle   = 1'b1;
   logic        m_add    = 1'b0;
   logic        m_ready  = 1'b0;
   logic        m_busy   = 1'b0;
   logic        m_bufrst = 1'b0;
   logic        m_frame  = 1'b0;
   logic [11:0] m_rgb    = '0;
   int          m_wr     = 0;

   typedef struct {
      logic        rst;
      logic        clr;
      logic        fst;
      logic [11:0] frgb;
      logic        val;
      logic [11:0] crgb;
      logic [27:0] exp;
   } vec_t;

   vec_t tv[11];

   function automatic logic [27:0] mk(input logic add, input logic rdy, input logic busy,
                                      input logic brst, input logic frm, input logic [11:0] rgb,
                                      input logic [10:0] wr);
      return {add, rdy, busy, brst, frm, rgb, wr};
   endfunction

   function automatic logic [27:0] dut_out();
      return {out_add_input, cpu_ready, fill_busy, out_buf_reset, frame_done, out_rgb, wr_index};
   endfunction

   task automatic push_pulse(input logic is_fill);
      for (int i = 0; i < HOLD; i++) sched.push_back('{1'b1, (i == 0), is_fill});
      for (int i = 0; i < GAP; i++) sched.push_back('{1'b0, 1'b0, is_fill});
   endtask

   task automatic model_edge();
      slot_t s;
      logic  popped;
      m_bufrst = 1'b0;
      m_frame  = 1'b0;
      if (reset) begin
         sched.delete();
         m_idle = 1'b1; m_add = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
         m_rgb = '0; m_wr = 0;
      end else if (clear_req) begin
         sched.delete();
         m_idle = 1'b0; m_add = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
         m_wr = 0; m_bufrst = 1'b1;
      end else begin
         if (m_idle) begin
            if (fill_start) begin
               m_rgb = fill_rgb;
               for (int p = 0; p < PIX_COUNT; p++) push_pulse(1'b1);
            end else if (cpu_valid && m_ready) begin
               m_rgb = cpu_rgb;
               push_pulse(1'b0);
            end
         end
         popped = (sched.size() > 0);
         s = popped ? sched.pop_front() : '0;
         m_add  = s.add;
         m_busy = s.fill;
         if (s.rise) begin
            m_wr    = (m_wr + 1) % PIX_COUNT;
            m_frame = (m_wr == 0);
         end
         m_idle  = !popped;
         m_ready = !popped;
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   // One clock edge: drive at negedge, update model at posedge, compare at next negedge
   task automatic step(input logic r, input logic c, input logic f, input logic [11:0] fr,
                       input logic v, input logic [11:0] cr);
      reset = r; clear_req = c; fill_start = f; fill_rgb = fr; cpu_valid = v; cpu_rgb = cr;
      @(posedge clk_50);
      model_edge();
      @(negedge clk_50);
      check_val("model", {4'h0, dut_out()},
                {4'h0, m_add, m_ready, m_busy, m_bufrst, m_frame, m_rgb, 11'(m_wr)});
      if (out_add_input && !prev_add) rises++;
      if (frame_done) frames++;
      prev_add = out_add_input;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
   endtask

   // Offer a pixel with cpu_valid held until the scheduler takes it
   task automatic cpu_write(input logic [11:0] rgb);
      logic rdy;
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         rdy = cpu_ready;
         step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, rgb);
         if (rdy) ok = 1'b1;
      end
      check_val("cpu_write_accepted", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 40 && !cpu_ready; n++) idle(1);
      check_val("wait_ready", {31'd0, cpu_ready}, 32'd1);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cyc;
      int rdy_viol;
      int rgb_viol;
      logic [11:0] crgb;

      // Reset, single CPU write of F0A, then clear+fill+cpu in the same idle cycle
      tv[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(0, 0, 0, 0, 0, 12'h000, 11'd0)};
      tv[1]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(0, 0, 0, 0, 0, 12'h000, 11'd0)};
      tv[2]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(0, 1, 0, 0, 0, 12'h000, 11'd0)};
      tv[3]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 12'hF0A, mk(1, 0, 0, 0, 0, 12'hF0A, 11'd1)};
      tv[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(1, 0, 0, 0, 0, 12'hF0A, 11'd1)};
      tv[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(0, 0, 0, 0, 0, 12'hF0A, 11'd1)};
      tv[6]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(0, 0, 0, 0, 0, 12'hF0A, 11'd1)};
      tv[7]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(0, 1, 0, 0, 0, 12'hF0A, 11'd1)};
      tv[8]  = '{1'b0, 1'b1, 1'b1, 12'h0F0, 1'b1, 12'h123, mk(0, 0, 0, 1, 0, 12'hF0A, 11'd0)};
      tv[9]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(0, 1, 0, 0, 0, 12'hF0A, 11'd0)};
      tv[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, mk(0, 1, 0, 0, 0, 12'hF0A, 11'd0)};

      for (int i = 0; i < 11; i++) begin
         step(tv[i].rst, tv[i].clr, tv[i].fst, tv[i].frgb, tv[i].val, tv[i].crgb);
         check_val($sformatf("vec%0d", i), {4'h0, dut_out()}, {4'h0, tv[i].exp});
      end

      // 1199 writes after reset, then the wrapping one
      step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
      step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
      rises = 0; frames = 0;
      for (int i = 0; i < PIX_COUNT - 1; i++) begin
         cpu_write(12'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      check_val("wr_after_1199", 32'(wr_index), 32'd1199);
      check_val("rises_after_1199", rises, 32'd1199);
      check_val("frames_before_wrap", frames, 32'd0);
      cpu_write(12'hABC);
      check_val("wr_wrapped", 32'(wr_index), 32'd0);
      check_val("frame_done_pulse", {31'd0, frame_done}, 32'd1);
      idle(1);
      check_val("frame_done_single", {31'd0, frame_done}, 32'd0);
      idle(5);
      check_val("frames_total", frames, 32'd1);
      check_val("rises_total", rises, 32'd1200);

      // Fill from wr_index 7 with a CPU pixel pending throughout
      step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000);
      for (int i = 0; i < 7; i++) cpu_write(12'($urandom));
      wait_ready();
      check_val("wr_before_fill", 32'(wr_index), 32'd7);
      rises = 0; frames = 0; busy_cyc = 0; rdy_viol = 0; rgb_viol = 0;
      crgb = 12'h3C3;
      step(1'b0, 1'b0, 1'b1, 12'h00F, 1'b1, crgb);
      for (int n = 0; n < 6000 && fill_busy; n++) begin
         busy_cyc++;
         if (cpu_ready) rdy_viol++;
         if (out_add_input && out_rgb != 12'h00F) rgb_viol++;
         step(1'b0, 1'b0, ($urandom_range(0, 63) == 0), 12'($urandom), 1'b1, crgb);
      end
      check_val("fill_rises", rises, 32'd1200);
      check_val("fill_wr_end", 32'(wr_index), 32'd7);
      check_val("fill_busy_cycles", busy_cyc, 32'(PIX_COUNT * (HOLD + GAP)));
      check_val("fill_ready_low", rdy_viol, 32'd0);
      check_val("fill_rgb_held", rgb_viol, 32'd0);
      check_val("fill_frames", frames, 32'd1);

      // Clear during the 500th fill pulse's high phase
      idle(1);
      wait_ready();
      rises = 0;
      step(1'b0, 1'b0, 1'b1, 12'h5A5, 1'b0, 12'h000);
      for (int n = 0; n < 3000 && rises < 500; n++) idle(1);
      check_val("pulse500_high", {31'd0, out_add_input}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000);
      check_val("clr_add_low", {31'd0, out_add_input}, 32'd0);
      check_val("clr_busy_low", {31'd0, fill_busy}, 32'd0);
      check_val("clr_buf_reset", {31'd0, out_buf_reset}, 32'd1);
      check_val("clr_wr_zero", 32'(wr_index), 32'd0);
      idle(1);
      check_val("clr_buf_reset_once", {31'd0, out_buf_reset}, 32'd0);
      check_val("clr_then_idle", {31'd0, cpu_ready}, 32'd1);
      check_val("clr_no_retry", rises, 32'd500);

      // Reset in the middle of a CPU high phase
      cpu_write(12'h777);
      check_val("pre_reset_high", {31'd0, out_add_input}, 32'd1);
      step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
      check_val("reset_all_zero", {4'h0, dut_out()}, 32'd0);
      idle(1);
      cpu_write(12'h135);
      check_val("post_reset_wr", 32'(wr_index), 32'd1);
      check_val("post_reset_add", {31'd0, out_add_input}, 32'd1);
      check_val("post_reset_rgb", 32'(out_rgb), 32'h135);

      // Random traffic against the model
      for (int n = 0; n < 2500; n++) begin
         step(1'b0, ($urandom_range(0, 199) == 0), ($urandom_range(0, 999) == 0),
              12'($urandom), 1'($urandom_range(0, 1)), 12'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
